trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Multi-cycle controller that owns the single write port of the machine-mode CSR register file.
- Idle: passes MEM-stage CSR instructions straight through to the CSR file.
- Trap or mret: takes over the port and writes mepc, mcause, mtval and mstatus in sequence, then redirects the PC to mtvec or mepc.
- Sits in the MEM stage, between the pipeline exception flags and the CSR file; drives pipeline flush, stall and redirect.

Parameters:
- CAUSE_EXT_IRQ, 32'h8000000B, mcause value written for an interrupt.
- RET_MPP, 2'b11, privilege mode written to mstatus.MPP on mret.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- csr_rw_in  in  1  MEM instruction is a CSR instruction
- csr_wsc_mode_in  in  2  01 write, 10 set, 11 clear
- csr_w_imm_mux  in  1  select zero-extended zimm as write data
- csr_rw_addr_in  in  12  CSR address
- csr_w_data_reg  in  32  rs1 data
- csr_w_data_imm  in  5  zimm
- csr_r_data_out  out  32  CSR read data returned to MEM
- interrupt, illegal_inst, l_access_fault, s_access_fault, ecall_m, mret  in  1 each  event flags
- inst_in  in  32  MEM instruction word
- fault_addr  in  32  load/store address
- epc_cur  in  32  PC of the faulting instruction
- epc_next  in  32  oldest unflushed PC
- csr_w  out  1  CSR file write enable
- csr_waddr, csr_raddr  out  12  CSR file write and read addresses
- csr_wdata  out  32  CSR file write data
- csr_wsc  out  2  CSR file write mode
- csr_rdata  in  32  CSR file read data, combinational on csr_raddr
- mstatus  in  32  current mstatus value
- PC_redirect  out  32  redirect target
- redirect_mux  out  1  take PC_redirect this cycle
- reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush  out  1 each  pipeline register flushes
- RegWrite_cancel  out  1  suppress register write of the trapping instruction
- seq_busy  out  1  stall PC and IF/ID

Behaviour:
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343.
- mstatus bit positions: MIE = bit 3, MPIE = bit 7, MPP = bits 12:11.
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, T_REDIR, R_MSTATUS, R_REDIR.
- Reset: state IDLE; all latched registers = 0; all outputs 0 except the IDLE pass-through values.
- trap is true when any of: illegal_inst, ecall_m, l_access_fault, s_access_fault, or (interrupt and mstatus[3]).
- Trap priority, with latched cause / epc / tval:
  - interrupt: CAUSE_EXT_IRQ / epc_next / 0
  - illegal_inst: 2 / epc_cur / inst_in
  - ecall_m: 11 / epc_cur / 0
  - l_access_fault: 5 / epc_cur / fault_addr
  - s_access_fault: 7 / epc_cur / fault_addr
- IDLE, no trap and no mret (pass-through):
  - csr_w = csr_rw_in; csr_raddr = csr_waddr = csr_rw_addr_in; csr_wsc = csr_wsc_mode_in.
  - csr_wdata = imm_mux ? {27'b0, zimm} : reg data.
  - csr_r_data_out = csr_rdata.
- IDLE and trap (cycle 0):
  - Latch cause, epc and tval.
  - Assert all four flushes and RegWrite_cancel; force csr_w = 0.
  - Go to W_MEPC.
- IDLE and mret (no trap): assert all four flushes, force csr_w = 0, go to R_MSTATUS.
- Trap and mret together: the trap wins.
- W_MEPC, W_MCAUSE, W_MTVAL: each writes its latched value, csr_w = 1, csr_wsc = 01.
- W_MSTATUS: writes mstatus with MPIE = MIE, MIE = 0, MPP = 11; all other bits unchanged.
- R_MSTATUS: writes mstatus with MIE = MPIE, MPIE = 1, MPP = RET_MPP.
- T_REDIR: csr_raddr = 0x305; PC_redirect = {csr_rdata[31:2], 2'b00}; redirect_mux = 1; flushes FD and DE; go to IDLE.
- R_REDIR: csr_raddr = 0x341; PC_redirect = csr_rdata; redirect_mux = 1; flushes FD and DE; go to IDLE.
- Latency: trap redirect in cycle 5; mret redirect in cycle 2.
- seq_busy = 1 in every non-IDLE state.
- Any event flag or csr_rw_in while non-IDLE is ignored.
- csr_r_data_out = 0 while non-IDLE.
- csr_w = 0 in both redirect states.
- Reset mid-sequence: return to IDLE immediately; no further CSR writes.

Test Plan:
- ecall_m, epc_cur = 0x100, mtvec = 0x204: cycles 1–4 write mepc 0x100, mcause 11, mtval 0, mstatus; cycle 5 PC_redirect = 0x204, redirect_mux = 1.
- illegal_inst, inst_in = 0xFFFFFFFF: mtval written as 0xFFFFFFFF, mcause 2; RegWrite_cancel = 1 in cycle 0 only.
- interrupt with MIE = 0: no response. interrupt with MIE = 1 and epc_next = 0x40: mepc 0x40, mcause 0x8000000B, MIE 1→0, MPIE = 1.
- mret with mepc = 0x88 and MPIE = 1: cycle 1 mstatus MIE = 1; cycle 2 PC_redirect = 0x88.
- IDLE csrrsi 0x300 with zimm 8: csr_w = 1, csr_wsc = 10, csr_wdata = 0x8, read data passed through unchanged. The same instruction while seq_busy: csr_w = 0.
- rst asserted in W_MCAUSE: state IDLE immediately, csr_w = 0, mcause not written. Simultaneous ecall_m and mret: trap sequence taken.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: owns the machine-mode CSR write port; passes MEM CSR ops through when idle,
// sequences mepc/mcause/mtval/mstatus writes on a trap (mstatus only on mret), then redirects the PC.
// Ports: csr_* in/out = MEM-side CSR request and read-back; event flags = trap/mret sources;
// csr_w/csr_waddr/csr_wdata/csr_wsc/csr_raddr/csr_rdata/mstatus = CSR file side;
// PC_redirect/redirect_mux/reg_*_flush/RegWrite_cancel/seq_busy = pipeline control.
module trap_sequencer #(
  parameter logic [31:0] CAUSE_EXT_IRQ = 32'h8000000B,
  parameter logic [1:0]  RET_MPP       = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_rw_in,
  input  logic [1:0]  csr_wsc_mode_in,
  input  logic        csr_w_imm_mux,
  input  logic [11:0] csr_rw_addr_in,
  input  logic [31:0] csr_w_data_reg,
  input  logic [4:0]  csr_w_data_imm,
  output logic [31:0] csr_r_data_out,
  input  logic        interrupt,
  input  logic        illegal_inst,
  input  logic        l_access_fault,
  input  logic        s_access_fault,
  input  logic        ecall_m,
  input  logic        mret,
  input  logic [31:0] inst_in,
  input  logic [31:0] fault_addr,
  input  logic [31:0] epc_cur,
  input  logic [31:0] epc_next,
  output logic        csr_w,
  output logic [11:0] csr_waddr,
  output logic [11:0] csr_raddr,
  output logic [31:0] csr_wdata,
  output logic [1:0]  csr_wsc,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] mstatus,
  output logic [31:0] PC_redirect,
  output logic        redirect_mux,
  output logic        reg_FD_flush,
  output logic        reg_DE_flush,
  output logic        reg_EM_flush,
  output logic        reg_MW_flush,
  output logic        RegWrite_cancel,
  output logic        seq_busy
);
  localparam logic [2:0] IDLE = 3'd0, W_MEPC = 3'd1, W_MCAUSE = 3'd2, W_MTVAL = 3'd3,
                         W_MSTATUS = 3'd4, T_REDIR = 3'd5, R_MSTATUS = 3'd6, R_REDIR = 3'd7;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MTVEC = 12'h305, A_MEPC = 12'h341,
                          A_MCAUSE = 12'h342, A_MTVAL = 12'h343;
  logic [2:0]  r_state, w_next;
  logic [31:0] r_cause, r_epc, r_tval;
  logic [31:0] w_cause, w_epc, w_tval, w_ms_trap, w_ms_ret;
  logic        w_idle, w_irq, w_trap, w_start, w_write, w_redir;
  assign w_idle  = r_state == IDLE;
  assign w_irq   = interrupt & mstatus[3];
  assign w_trap  = w_irq | illegal_inst | ecall_m | l_access_fault | s_access_fault;
  assign w_start = w_idle & (w_trap | mret);
  assign w_redir = r_state == T_REDIR || r_state == R_REDIR;
  assign w_write = !w_idle && !w_redir;
  assign w_cause = w_irq ? CAUSE_EXT_IRQ : illegal_inst ? 32'd2 : ecall_m ? 32'd11 :
                   l_access_fault ? 32'd5 : 32'd7;
  assign w_epc   = w_irq ? epc_next : epc_cur;
  assign w_tval  = (w_irq || (!illegal_inst && ecall_m)) ? 32'd0 : illegal_inst ? inst_in : fault_addr;
  // trap entry: MPIE <= MIE, MIE <= 0, MPP <= 11
  assign w_ms_trap = {mstatus[31:13], 2'b11, mstatus[10:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]};
  // mret: MIE <= MPIE, MPIE <= 1, MPP <= RET_MPP
  assign w_ms_ret  = {mstatus[31:13], RET_MPP, mstatus[10:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]};
  assign w_next = w_idle ? (w_trap ? W_MEPC : mret ? R_MSTATUS : IDLE) :
                  w_redir ? IDLE :
                  r_state == W_MSTATUS ? T_REDIR :
                  r_state == R_MSTATUS ? R_REDIR : r_state + 3'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cause <= '0;
      r_epc   <= '0;
      r_tval  <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && w_trap) begin
        r_cause <= w_cause;
        r_epc   <= w_epc;
        r_tval  <= w_tval;
      end
    end
  end
  assign csr_w     = w_idle ? csr_rw_in & ~w_start : w_write;
  assign csr_wsc   = w_idle ? csr_wsc_mode_in : w_write ? 2'b01 : 2'b00;
  assign csr_waddr = w_idle ? csr_rw_addr_in :
                     r_state == W_MEPC ? A_MEPC :
                     r_state == W_MCAUSE ? A_MCAUSE :
                     r_state == W_MTVAL ? A_MTVAL :
                     w_write ? A_MSTATUS : 12'h000;
  assign csr_wdata = w_idle ? (csr_w_imm_mux ? {27'b0, csr_w_data_imm} : csr_w_data_reg) :
                     r_state == W_MEPC ? r_epc :
                     r_state == W_MCAUSE ? r_cause :
                     r_state == W_MTVAL ? r_tval :
                     r_state == W_MSTATUS ? w_ms_trap :
                     r_state == R_MSTATUS ? w_ms_ret : 32'd0;
  assign csr_raddr = w_idle ? csr_rw_addr_in : r_state == T_REDIR ? A_MTVEC :
                     r_state == R_REDIR ? A_MEPC : 12'h000;
  assign csr_r_data_out  = w_idle ? csr_rdata : 32'd0;
  assign PC_redirect     = r_state == T_REDIR ? {csr_rdata[31:2], 2'b00} :
                           r_state == R_REDIR ? csr_rdata : 32'd0;
  assign redirect_mux    = w_redir;
  assign reg_FD_flush    = w_start | w_redir;
  assign reg_DE_flush    = w_start | w_redir;
  assign reg_EM_flush    = w_start;
  assign reg_MW_flush    = w_start;
  assign RegWrite_cancel = w_idle & w_trap;
  assign seq_busy        = !w_idle;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: scoreboard bench with a behavioural CSR file and trap/mret reference model.
module tb_trap_sequencer;
  localparam logic [5:0] F_IRQ = 6'b100000, F_ILL = 6'b010000, F_EC = 6'b000010, F_MR = 6'b000001;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        csr_rw_in, csr_w_imm_mux, interrupt, illegal_inst, l_access_fault, s_access_fault, ecall_m, mret;
  logic [1:0]  csr_wsc_mode_in;
  logic [11:0] csr_rw_addr_in;
  logic [31:0] csr_w_data_reg, inst_in, fault_addr, epc_cur, epc_next, csr_rdata, mstatus;
  logic [4:0]  csr_w_data_imm;
  logic [31:0] csr_r_data_out, csr_wdata, PC_redirect;
  logic        csr_w, redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush, RegWrite_cancel, seq_busy;
  logic [11:0] csr_waddr, csr_raddr;
  logic [1:0]  csr_wsc;
  trap_sequencer dut (
    .clk(clk), .rst(rst), .csr_rw_in(csr_rw_in), .csr_wsc_mode_in(csr_wsc_mode_in),
    .csr_w_imm_mux(csr_w_imm_mux), .csr_rw_addr_in(csr_rw_addr_in), .csr_w_data_reg(csr_w_data_reg),
    .csr_w_data_imm(csr_w_data_imm), .csr_r_data_out(csr_r_data_out), .interrupt(interrupt),
    .illegal_inst(illegal_inst), .l_access_fault(l_access_fault), .s_access_fault(s_access_fault),
    .ecall_m(ecall_m), .mret(mret), .inst_in(inst_in), .fault_addr(fault_addr), .epc_cur(epc_cur),
    .epc_next(epc_next), .csr_w(csr_w), .csr_waddr(csr_waddr), .csr_raddr(csr_raddr),
    .csr_wdata(csr_wdata), .csr_wsc(csr_wsc), .csr_rdata(csr_rdata), .mstatus(mstatus),
    .PC_redirect(PC_redirect), .redirect_mux(redirect_mux), .reg_FD_flush(reg_FD_flush),
    .reg_DE_flush(reg_DE_flush), .reg_EM_flush(reg_EM_flush), .reg_MW_flush(reg_MW_flush),
    .RegWrite_cancel(RegWrite_cancel), .seq_busy(seq_busy)
  );
  logic [31:0] m_status = '0, m_tvec = '0, m_epc = '0, m_cause = '0, m_tval = '0;
  function automatic logic [31:0] rd(input logic [11:0] a);
    case (a)
      12'h300: rd = m_status;
      12'h305: rd = m_tvec;
      12'h341: rd = m_epc;
      12'h342: rd = m_cause;
      12'h343: rd = m_tval;
      default: rd = {20'hC5A00, a};
    endcase
  endfunction
  function automatic logic [31:0] upd(input logic [31:0] o, input logic [1:0] m, input logic [31:0] d);
    upd = m == 2'b01 ? d : m == 2'b10 ? (o | d) : m == 2'b11 ? (o & ~d) : o;
  endfunction
  assign csr_rdata = rd(csr_raddr);
  assign mstatus   = m_status;
  always @(posedge clk) begin
    if (!rst && csr_w) begin
      case (csr_waddr)
        12'h300: m_status <= upd(m_status, csr_wsc, csr_wdata);
        12'h305: m_tvec   <= upd(m_tvec, csr_wsc, csr_wdata);
        12'h341: m_epc    <= upd(m_epc, csr_wsc, csr_wdata);
        12'h342: m_cause  <= upd(m_cause, csr_wsc, csr_wdata);
        12'h343: m_tval   <= upd(m_tval, csr_wsc, csr_wdata);
        default: ;
      endcase
    end
  end
  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;
  typedef struct packed {
    logic        k;
    logic [31:0] cy;
    logic [11:0] a;
    logic [1:0]  m;
    logic [31:0] d;
  } ev_t;
  ev_t q[$];
  int n_vec = 0, n_err = 0;
  task automatic push(input logic k, input logic [31:0] cy, input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
    q.push_back('{k: k, cy: cy, a: a, m: m, d: d});
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, got, exp);
    end
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (!rst && csr_w) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write @cyc %0d: addr %h data %h, expected none", cyc, csr_waddr, csr_wdata);
      end else begin
        e = q.pop_front();
        if (e.k || e.cy != cyc || e.a != csr_waddr || e.m != csr_wsc || e.d != csr_wdata) begin
          n_err++;
          $display("FAIL csr_write @cyc %0d: got addr %h wsc %b data %h, expected kind %0d cyc %0d addr %h wsc %b data %h",
                   cyc, csr_waddr, csr_wsc, csr_wdata, e.k, e.cy, e.a, e.m, e.d);
        end
      end
    end
    if (!rst && redirect_mux) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_redirect @cyc %0d: pc %h, expected none", cyc, PC_redirect);
      end else begin
        e = q.pop_front();
        if (!e.k || e.cy != cyc || e.d != PC_redirect ||
            {reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush, seq_busy} != 5'b11001) begin
          n_err++;
          $display("FAIL redirect @cyc %0d: got pc %h flush/busy %b, expected kind %0d cyc %0d pc %h flush/busy 11001",
                   cyc, PC_redirect, {reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush, seq_busy}, e.k, e.cy, e.d);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    {interrupt, illegal_inst, l_access_fault, s_access_fault, ecall_m, mret} = '0;
    csr_rw_in = 0; csr_wsc_mode_in = 0; csr_w_imm_mux = 0; csr_rw_addr_in = 0;
    csr_w_data_reg = 0; csr_w_data_imm = 0;
  endtask
  task automatic noise();
    {interrupt, illegal_inst, l_access_fault, s_access_fault, ecall_m, mret} = 6'($urandom);
    csr_rw_in = 1'($urandom); csr_wsc_mode_in = 2'($urandom); csr_w_imm_mux = 1'($urandom);
    csr_rw_addr_in = 12'($urandom); csr_w_data_reg = $urandom; csr_w_data_imm = 5'($urandom);
  endtask
  task automatic csr_op(input logic [1:0] m, input logic im, input logic [11:0] a, input logic [31:0] d, input logic [4:0] z);
    tick();
    clear_in();
    csr_rw_in = 1; csr_wsc_mode_in = m; csr_w_imm_mux = im; csr_rw_addr_in = a;
    csr_w_data_reg = d; csr_w_data_imm = z;
    push(1'b0, cyc, a, m, im ? {27'b0, z} : d);
    @(negedge clk);
    chk("rdata_pass", {32'b0, csr_r_data_out}, {32'b0, rd(a)});
  endtask
  // f = {interrupt, illegal, load fault, store fault, ecall, mret}; abort>0 asserts rst in that busy cycle
  task automatic run_event(input logic [5:0] f, input int abort);
    logic irq, trap;
    logic [31:0] c, cs, ep, tv, ms;
    int n;
    tick();
    clear_in();
    c = cyc;
    irq = f[5] & m_status[3];
    trap = irq | f[4] | f[3] | f[2] | f[1];
    ms = m_status;
    n = 0;
    if (trap) begin
      cs = irq ? 32'h8000000B : f[4] ? 32'd2 : f[1] ? 32'd11 : f[3] ? 32'd5 : 32'd7;
      ep = irq ? epc_next : epc_cur;
      tv = (irq || (!f[4] && f[1])) ? 32'd0 : f[4] ? inst_in : fault_addr;
      ms[7] = ms[3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
      push(1'b0, c + 1, 12'h341, 2'b01, ep);
      push(1'b0, c + 2, 12'h342, 2'b01, cs);
      push(1'b0, c + 3, 12'h343, 2'b01, tv);
      push(1'b0, c + 4, 12'h300, 2'b01, ms);
      push(1'b1, c + 5, 12'h000, 2'b00, {m_tvec[31:2], 2'b00});
      n = 5;
    end else if (f[0]) begin
      ms[3] = ms[7]; ms[7] = 1'b1; ms[12:11] = 2'b11;
      push(1'b0, c + 1, 12'h300, 2'b01, ms);
      push(1'b1, c + 2, 12'h000, 2'b00, m_epc);
      n = 2;
    end
    {interrupt, illegal_inst, l_access_fault, s_access_fault, ecall_m, mret} = f;
    if (trap || f[0]) begin
      csr_rw_in = 1'($urandom); csr_wsc_mode_in = 2'b01; csr_rw_addr_in = 12'h341; csr_w_data_reg = $urandom;
    end
    @(negedge clk);
    chk("cycle0_ctl", {57'b0, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush, RegWrite_cancel, csr_w, seq_busy},
        {57'b0, trap ? 7'b1111100 : f[0] ? 7'b1111000 : 7'b0000000});
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == abort) begin
        q.delete();
        rst = 1;
        clear_in();
        @(negedge clk);
        chk("abort_idle", {61'b0, csr_w, seq_busy, redirect_mux}, 64'd0);
        tick();
        tick();
        rst = 0;
        break;
      end
      noise();
      @(negedge clk);
      chk("busy_hold", {30'b0, seq_busy, RegWrite_cancel, csr_r_data_out}, {30'b0, 1'b1, 1'b0, 32'd0});
    end
    tick();
    clear_in();
    @(negedge clk);
    chk("drain", {31'b0, seq_busy, 32'(q.size())}, 64'd0);
  endtask
  initial begin
    #400000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
  initial begin
    logic [11:0] al [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h7C0};
    clear_in();
    inst_in = 0; fault_addr = 0; epc_cur = 0; epc_next = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {31'b0, csr_w, seq_busy, redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush,
                      RegWrite_cancel, PC_redirect[24:0]}, 64'd0);
    chk("reset_pass", {32'b0, csr_r_data_out}, {32'b0, rd(12'h000)});
    @(posedge clk);
    #1 rst = 0;
    csr_op(2'b01, 1'b0, 12'h305, 32'h0000_0204, 5'd0);
    epc_cur = 32'h100;
    run_event(F_EC, 0);
    inst_in = 32'hFFFF_FFFF;
    run_event(F_ILL, 0);
    csr_op(2'b11, 1'b1, 12'h300, 32'h0, 5'd8);
    run_event(F_IRQ, 0);
    csr_op(2'b10, 1'b1, 12'h300, 32'h0, 5'd8);
    epc_next = 32'h40;
    run_event(F_IRQ, 0);
    csr_op(2'b01, 1'b0, 12'h341, 32'h88, 5'd0);
    run_event(F_MR, 0);
    epc_cur = 32'h300;
    run_event(F_EC, 2);
    run_event(F_EC | F_MR, 0);
    for (int k = 0; k < 60; k++) begin
      epc_cur = $urandom; epc_next = $urandom; inst_in = $urandom; fault_addr = $urandom;
      case ($urandom_range(0, 3))
        0: csr_op(2'($urandom_range(1, 3)), 1'($urandom), al[$urandom_range(0, 5)], $urandom, 5'($urandom));
        1, 2: run_event(6'($urandom), 0);
        default: run_event(F_MR, 0);
      endcase
    end
    tick();
    clear_in();
    repeat (3) tick();
    @(negedge clk);
    chk("final_drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
